// File: rtl/branch_con_unit_if.sv
// rtl/branch_con_unit_if.sv - handshake and status bundle between control unit and branch_con_unit
//
// Purpose: groups the request/acknowledge handshake, the operands being
// tested and the result/statistics outputs of branch_con_unit.
// Signals:
//   ir            control -> unit  instruction register (condition field inside)
//   bus_in        control -> unit  BusMuxOut value under test
//   con_in        control -> unit  evaluate request, level (edge detected in unit)
//   con_ack       control -> unit  result consumed
//   con           unit -> control  registered branch decision
//   con_valid     unit -> control  con holds an unconsumed result
//   overrun       unit -> control  sticky, request while result unconsumed
//   taken_cnt     unit -> control  saturating count of results equal to 1
//   not_taken_cnt unit -> control  saturating count of results equal to 0
interface branch_con_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [31:0]       ir;
  logic [DATA_W-1:0] bus_in;
  logic              con_in;
  logic              con_ack;
  logic              con;
  logic              con_valid;
  logic              overrun;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  not_taken_cnt;

  modport master (
    output ir, bus_in, con_in, con_ack,
    input  con, con_valid, overrun, taken_cnt, not_taken_cnt
  );

  modport slave (
    input  ir, bus_in, con_in, con_ack,
    output con, con_valid, overrun, taken_cnt, not_taken_cnt
  );
endinterface

// File: rtl/branch_con_unit.sv
// rtl/branch_con_unit.sv - clocked branch-condition evaluator with handshake and statistics
//
// Purpose: on a rising edge of con_in, evaluates one of eight condition codes
// (ir[COND_LSB+2:COND_LSB]) against bus_in, latches the decision into con and
// holds it with con_valid until con_ack. Requests arriving while a result is
// unconsumed are dropped and flagged on the sticky overrun output. Keeps
// saturating taken / not-taken counters.
// Ports:
//   clock    rising-edge clock
//   clear_n  asynchronous active-low reset
//   bif      branch_con_unit_if slave modport (see interface for signal list)
module branch_con_unit #(
  parameter int DATA_W   = 32,
  parameter int COND_LSB = 19,
  parameter int CNT_W    = 16
) (
  input logic              clock,
  input logic              clear_n,
  branch_con_unit_if.slave bif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             con_in_q, con_in_d;
  logic             con_q, con_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] not_taken_q, not_taken_d;

  logic       req;
  logic       accept;
  logic       result;
  logic       zero;
  logic       neg;
  logic [2:0] cond;

  assign cond = bif.ir[COND_LSB+2:COND_LSB];
  assign zero = (bif.bus_in == '0);
  assign neg  = bif.bus_in[DATA_W-1];

  // con_in_q resets to 0, so a con_in already high at reset release counts as a request.
  assign req = bif.con_in & ~con_in_q;

  always_comb begin
    result = 1'b0;
    case (cond)
      3'b000: result = zero;
      3'b001: result = ~zero;
      3'b010: result = ~neg;
      3'b011: result = neg;
      3'b100: result = ~neg & ~zero;
      3'b101: result = neg | zero;
      3'b110: result = 1'b1;
      3'b111: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

  // State register together with the datapath flops.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      con_in_q    <= 1'b0;
      con_q       <= 1'b0;
      overrun_q   <= 1'b0;
      taken_q     <= '0;
      not_taken_q <= '0;
    end else begin
      state_q     <= state_d;
      con_in_q    <= con_in_d;
      con_q       <= con_d;
      overrun_q   <= overrun_d;
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
    end
  end

  // Next state. An ack coinciding with a new request keeps us in HOLD
  // because the new result immediately becomes the unconsumed one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = HOLD;
      HOLD:    if (bif.con_ack && !req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    con_in_d    = bif.con_in;
    accept      = req && ((state_q == IDLE) || bif.con_ack);
    con_d       = accept ? result : con_q;
    overrun_d   = overrun_q | (req && (state_q == HOLD) && !bif.con_ack);
    taken_d     = taken_q;
    not_taken_d = not_taken_q;
    if (accept) begin
      if (result) begin
        if (taken_q != CNT_MAX) taken_d = taken_q + CNT_ONE;
      end else begin
        if (not_taken_q != CNT_MAX) not_taken_d = not_taken_q + CNT_ONE;
      end
    end
  end

  // Outputs.
  always_comb begin
    bif.con           = con_q;
    bif.con_valid     = (state_q == HOLD);
    bif.overrun       = overrun_q;
    bif.taken_cnt     = taken_q;
    bif.not_taken_cnt = not_taken_q;
  end

endmodule

// File: tb/tb_branch_con_unit.sv
// tb/tb_branch_con_unit.sv - scoreboard testbench for branch_con_unit
module tb_branch_con_unit;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  branch_con_unit_if #(.DATA_W(32), .CNT_W(16)) m_if ();
  branch_con_unit_if #(.DATA_W(32), .CNT_W(2))  s_if ();
  branch_con_unit_if #(.DATA_W(8),  .CNT_W(16)) w_if ();

  branch_con_unit #(.DATA_W(32), .COND_LSB(19), .CNT_W(16)) u_main (
    .clock(clock), .clear_n(clear_n), .bif(m_if)
  );
  branch_con_unit #(.DATA_W(32), .COND_LSB(19), .CNT_W(2)) u_sat (
    .clock(clock), .clear_n(clear_n), .bif(s_if)
  );
  branch_con_unit #(.DATA_W(8), .COND_LSB(19), .CNT_W(16)) u_w8 (
    .clock(clock), .clear_n(clear_n), .bif(w_if)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse;
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
  endtask

  // Monitor: every accepted evaluation bumps the main unit's counter sum;
  // that is when the next expected decision is popped and compared.
  logic [16:0] prev_sum = '0;
  logic [16:0] cur_sum;
  bit          exp_bit;
  always @(negedge clock) begin
    cur_sum = {1'b0, m_if.taken_cnt} + {1'b0, m_if.not_taken_cnt};
    if (cur_sum > prev_sum) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_eval: got con=%0b with no expected result queued", m_if.con);
      end else begin
        exp_bit = exp_q.pop_front();
        chk("con_result", {63'd0, m_if.con}, {63'd0, exp_bit});
      end
    end
    prev_sum = cur_sum;
  end

  logic [31:0] buses[3];
  logic [7:0]  tab[3];

  initial begin
    buses[0] = 32'h0000_0000;
    buses[1] = 32'h0000_0005;
    buses[2] = 32'h8000_0000;
    // bit c of tab[i] is the expected con for condition code c
    tab[0] = 8'b0110_0101;
    tab[1] = 8'b0101_0110;
    tab[2] = 8'b0110_1010;

    clear_n = 1'b0;
    m_if.ir = '0; m_if.bus_in = '0; m_if.con_in = 1'b0; m_if.con_ack = 1'b0;
    s_if.ir = '0; s_if.bus_in = '0; s_if.con_in = 1'b0; s_if.con_ack = 1'b0;
    w_if.ir = '0; w_if.bus_in = '0; w_if.con_in = 1'b0; w_if.con_ack = 1'b0;

    step();
    chk("rst_con", m_if.con, 0);
    chk("rst_valid", m_if.con_valid, 0);
    chk("rst_overrun", m_if.overrun, 0);
    chk("rst_taken", m_if.taken_cnt, 0);
    chk("rst_not_taken", m_if.not_taken_cnt, 0);

    // con_in high through reset: first edge after release is a request
    m_if.ir = 32'(6) << 19;
    m_if.con_in = 1'b1;
    step();
    chk("rst_hold_valid", m_if.con_valid, 0);
    clear_n = 1'b1;
    exp_q.push_back(1'b1);
    step();
    m_if.con_in = 1'b0;
    chk("release_req_valid", m_if.con_valid, 1);
    chk("release_req_taken", m_if.taken_cnt, 1);

    // asynchronous reset in HOLD, between edges
    @(negedge clock);
    #1;
    clear_n = 1'b0;
    #1;
    chk("async_rst_con", m_if.con, 0);
    chk("async_rst_valid", m_if.con_valid, 0);
    chk("async_rst_taken", m_if.taken_cnt, 0);
    step();
    clear_n = 1'b1;

    // all codes against three operands, each acknowledged
    for (int bi = 0; bi < 3; bi++) begin
      for (int c = 0; c < 8; c++) begin
        m_if.bus_in = buses[bi];
        m_if.ir = (32'(c) << 19) | 32'h0044_0000;
        m_if.con_in = 1'b1;
        exp_q.push_back(tab[bi][c]);
        step();
        m_if.con_in = 1'b0;
        m_if.con_ack = 1'b1;
        step();
        m_if.con_ack = 1'b0;
        chk("sweep_ack_valid", m_if.con_valid, 0);
      end
    end
    chk("sweep_taken", m_if.taken_cnt, 12);
    chk("sweep_not_taken", m_if.not_taken_cnt, 12);

    // held-high con_in yields a single evaluation
    reset_pulse();
    m_if.ir = 32'(6) << 19;
    chk("level_valid_before", m_if.con_valid, 0);
    m_if.con_in = 1'b1;
    exp_q.push_back(1'b1);
    step();
    chk("level_valid_rise", m_if.con_valid, 1);
    repeat (4) step();
    m_if.con_in = 1'b0;
    chk("level_taken", m_if.taken_cnt, 1);
    chk("level_not_taken", m_if.not_taken_cnt, 0);
    m_if.con_ack = 1'b1;
    step();
    m_if.con_ack = 1'b0;
    chk("level_ack_valid", m_if.con_valid, 0);

    // overrun: second request without ack is discarded
    reset_pulse();
    m_if.ir = '0;
    m_if.bus_in = '0;
    m_if.con_in = 1'b1;
    exp_q.push_back(1'b1);
    step();
    m_if.con_in = 1'b0;
    step();
    m_if.ir = 32'(7) << 19;
    m_if.con_in = 1'b1;
    step();
    m_if.con_in = 1'b0;
    chk("ovr_con", m_if.con, 1);
    chk("ovr_flag", m_if.overrun, 1);
    chk("ovr_not_taken", m_if.not_taken_cnt, 0);
    chk("ovr_valid", m_if.con_valid, 1);
    m_if.con_ack = 1'b1;
    step();
    m_if.con_ack = 1'b0;
    chk("ovr_ack_valid", m_if.con_valid, 0);
    chk("ovr_sticky", m_if.overrun, 1);

    // ack and new request on the same edge
    reset_pulse();
    m_if.ir = 32'(6) << 19;
    m_if.con_in = 1'b1;
    exp_q.push_back(1'b1);
    step();
    m_if.con_in = 1'b0;
    step();
    m_if.ir = 32'(1) << 19;
    m_if.bus_in = '0;
    m_if.con_in = 1'b1;
    m_if.con_ack = 1'b1;
    exp_q.push_back(1'b0);
    step();
    m_if.con_in = 1'b0;
    m_if.con_ack = 1'b0;
    chk("simul_con", m_if.con, 0);
    chk("simul_valid", m_if.con_valid, 1);
    chk("simul_overrun", m_if.overrun, 0);
    chk("simul_not_taken", m_if.not_taken_cnt, 1);
    chk("simul_taken", m_if.taken_cnt, 1);
    m_if.con_ack = 1'b1;
    step();
    m_if.con_ack = 1'b0;

    // saturation with 2-bit counters
    s_if.ir = 32'(6) << 19;
    for (int i = 0; i < 5; i++) begin
      s_if.con_in = 1'b1;
      step();
      s_if.con_in = 1'b0;
      s_if.con_ack = 1'b1;
      step();
      s_if.con_ack = 1'b0;
      chk("sat_taken", s_if.taken_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    repeat (3) step();
    chk("sat_hold", s_if.taken_cnt, 3);
    chk("sat_not_taken", s_if.not_taken_cnt, 0);
    chk("sat_con", s_if.con, 1);

    // 8-bit data path sign bit
    w_if.ir = 32'(3) << 19;
    w_if.bus_in = 8'h80;
    w_if.con_in = 1'b1;
    step();
    w_if.con_in = 1'b0;
    chk("w8_neg_con", w_if.con, 1);
    w_if.con_ack = 1'b1;
    step();
    w_if.con_ack = 1'b0;
    w_if.bus_in = 8'h7F;
    w_if.con_in = 1'b1;
    step();
    w_if.con_in = 1'b0;
    chk("w8_pos_con", w_if.con, 0);
    w_if.con_ack = 1'b1;
    step();
    w_if.con_ack = 1'b0;

    repeat (2) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
